// File: rtl/seq_mem_reader.sv
// Read-side sequencer for the sample buffer: walks addresses 0..last_addr through a
// synchronous RAM read port onto a valid/ready stream. Optional READ_DESCEND_EN adds descending walks.
module seq_mem_reader #(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] last_addr,
`ifdef READ_DESCEND_EN
    input  logic          descend,
`endif
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] limit_q, limit_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          desc_q, desc_d;
    logic          desc_in;

`ifdef READ_DESCEND_EN
    assign desc_in = descend;
`else
    assign desc_in = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            limit_q    <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            desc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            limit_q    <= limit_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            desc_q     <= desc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        limit_d    = limit_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        desc_d     = desc_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    limit_d = last_addr;
                    desc_d  = desc_in;
                    addr_d  = desc_in ? last_addr : '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                out_data_d = rd_data;
                out_last_d = desc_q ? (addr_q == '0) : (addr_q == limit_q);
                state_d    = S_PRESENT;
            end
            S_PRESENT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = desc_q ? (addr_q - AW'(1)) : (addr_q + AW'(1));
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // addr_q only moves on entry to FETCH, so it doubles as the held read address.
    assign rd_en     = (state_q == S_FETCH);
    assign rd_addr   = addr_q;
    assign out_data  = out_data_q;
    assign out_valid = (state_q == S_PRESENT);
    assign out_last  = out_last_q && (state_q == S_PRESENT);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_mem_reader.sv
// Directed self-checking bench for seq_mem_reader with a synchronous RAM model (mem[i] = i + 8'h10).
module tb_seq_mem_reader;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] last_addr;
    logic          descend;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [64];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_mem_reader #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .last_addr (last_addr),
`ifdef READ_DESCEND_EN
        .descend   (descend),
`endif
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One readout from start to the cycle after done; inputs driven and outputs sampled at negedge.
    task automatic readout(input int unsigned la, input bit toggle, input bit desc,
                           input bit restart, input int unsigned exp_busy);
        int unsigned k = 0, nrd = 0, ndone = 0, busy_n = 0, first_v = 0, hs_cyc = 0, ea = 0;
        int unsigned c = 1;
        bit stall = 0, fin = 0, v_seen = 0, dprev = 0, restarted = 0;
        logic [DW-1:0] hold_d = '0;
        logic          hold_l = 1'b0;
        start     = 1'b1;
        last_addr = AW'(la);
        descend   = desc;
        @(negedge clk);
        start     = 1'b0;
        last_addr = ~last_addr;
        while (!fin && c < 400) begin
            ea = desc ? (la - k) : k;
            if (busy) busy_n++;
            if (rd_en) begin
                chk("rd_addr", 32'(rd_addr), ea);
                nrd++;
            end
            if (stall) begin
                chk("stall valid held", 32'(out_valid), 1);
                chk("stall data held", 32'(out_data), 32'(hold_d));
                chk("stall last held", 32'(out_last), 32'(hold_l));
            end
            if (out_valid) begin
                if (!v_seen) begin
                    v_seen  = 1;
                    first_v = c;
                end
                chk("no rd_en while presenting", 32'(rd_en), 0);
            end else begin
                chk("out_last without valid", 32'(out_last), 0);
            end
            if (dprev) begin
                chk("busy after done", 32'(busy), 0);
                fin = 1;
            end
            if (done) begin
                ndone++;
                chk("done one cycle after last handshake", c, hs_cyc + 1);
                chk("words before done", k, la + 1);
            end
            dprev     = done;
            out_ready = toggle ? (c % 2 == 1) : 1'b1;
            start     = 1'b0;
            if (restart && out_valid && k == 1 && !restarted) begin
                start     = 1'b1;
                restarted = 1;
            end
            stall = out_valid && !out_ready;
            if (out_valid && out_ready) begin
                chk("out_data", 32'(out_data), 32'(8'h10) + ea);
                chk("out_last", 32'(out_last), (k == la) ? 1 : 0);
                k++;
                hs_cyc = c;
            end
            hold_d = out_data;
            hold_l = out_last;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk("readout finished within budget", 32'(fin), 1);
        chk("word count", k, la + 1);
        chk("rd_en count", nrd, la + 1);
        chk("done pulse count", ndone, 1);
        chk("first out_valid cycle", first_v, 3);
        if (exp_busy != 0) chk("busy cycles", busy_n, exp_busy);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i + 16);
        reset     = 1'b1;
        start     = 1'b0;
        last_addr = '0;
        descend   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset rd_en", 32'(rd_en), 0);
        chk("reset rd_addr", 32'(rd_addr), 0);
        chk("reset out_data", 32'(out_data), 0);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out_last", 32'(out_last), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        reset = 1'b0;
        @(negedge clk);

        // Four words, ready tied high: 3 cycles per word plus DONE.
        readout(3, 1'b0, 1'b0, 1'b0, 13);
        // Single word.
        readout(0, 1'b0, 1'b0, 1'b0, 4);
        // Full buffer with ready toggling.
        readout(63, 1'b1, 1'b0, 1'b0, 0);
        // Start pulse during PRESENT of word 1 is ignored.
        readout(5, 1'b0, 1'b0, 1'b1, 19);

        // Reset during WAIT of word 2.
        out_ready = 1'b1;
        start     = 1'b1;
        last_addr = 6'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("in WAIT before reset busy", 32'(busy), 1);
        chk("in WAIT before reset valid", 32'(out_valid), 0);
        chk("in WAIT before reset rd_addr", 32'(rd_addr), 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset rd_en", 32'(rd_en), 0);
        chk("mid reset rd_addr", 32'(rd_addr), 0);
        chk("mid reset out_data", 32'(out_data), 0);
        chk("mid reset out_valid", 32'(out_valid), 0);
        chk("mid reset out_last", 32'(out_last), 0);
        chk("mid reset busy", 32'(busy), 0);
        chk("mid reset done", 32'(done), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no done after reset", 32'(done), 0);
            chk("idle after reset", 32'(busy), 0);
        end
        readout(1, 1'b0, 1'b0, 1'b0, 7);

`ifdef READ_DESCEND_EN
        readout(3, 1'b0, 1'b1, 1'b0, 13);
        readout(2, 1'b0, 1'b0, 1'b0, 10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mem_reader.md
Name: seq_mem_reader

Overview:
Read-side sequencer for the 64-word sample buffer, which is filled by the incrementing 6-bit address counter. On a start pulse it walks buffer addresses from 0 up to a programmed last address. It issues synchronous RAM reads and presents each word on a valid/ready output stream, with a last-word flag and a completion pulse. It sits between the sample RAM read port and the downstream consumer (serializer/display path).

Parameters:
DW, 8, data word width (bits)
AW, 6, address width; buffer depth 2**AW

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a readout; honoured only in IDLE
last_addr  input  AW  final address of the readout; sampled on accepted start; word count = last_addr+1
rd_en  output  1  RAM read enable
rd_addr  output  AW  RAM read address
rd_data  input  DW  RAM read data, valid the cycle after rd_en was high
out_data  output  DW  stream data
out_valid  output  1  stream data valid
out_ready  input  1  consumer accepts when high with out_valid
out_last  output  1  high with out_valid on the final word
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Single clock clk. reset is synchronous and active-high. Both are fixed.
- Reset values: state=IDLE, rd_en=0, rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, internal address/limit regs=0.
- Reset has priority over every other input, including mid-readout. Any word in flight is discarded and no done pulse is issued.
- FSM states: IDLE, FETCH, WAIT, PRESENT, DONE.
- IDLE: if start=1, latch last_addr into limit, set addr=0, and go to FETCH. Otherwise stay in IDLE.
- start is ignored in all non-IDLE states. It is also ignored in the DONE cycle.
- FETCH (1 cycle): rd_en=1, rd_addr=addr, then go to WAIT. rd_en is 0 in every other state.
- WAIT (1 cycle): capture rd_data into out_data. Set out_last=(addr==limit). Go to PRESENT.
- PRESENT: out_valid=1. out_data and out_last are held stable until handshake (out_valid & out_ready at a clock edge).
  - On handshake with out_last=0: addr=addr+1 and go to FETCH.
  - On handshake with out_last=1: go to DONE.
  - Without handshake: stay in PRESENT.
- out_valid deasserts in the cycle after handshake. It never drops without handshake, except on reset.
- DONE (1 cycle): done=1, then go to IDLE. busy=0 from IDLE onward.
- Latency: start at edge N → rd_en high in cycle N+1 → out_valid high in cycle N+3. Minimum 3 cycles per word when out_ready is tied high.
- Boundaries:
  - last_addr=0: exactly one word is read (address 0), with out_last=1.
  - last_addr=2**AW-1: full buffer of 64 words.
  - addr never wraps, because the limit is reached first.
- rd_addr holds its last driven value outside FETCH.
- last_addr changes after the start is accepted have no effect on the current readout.

Optional Feature:
Macro READ_DESCEND_EN.
- Defined: add input port descend (1 bit), sampled with start. When descend=1, addr starts at last_addr and decrements, and out_last is asserted at addr==0. Word count is unchanged. When descend=0, behaviour is identical to the ascending mode.
- Undefined: no descend port exists; readout is always ascending from 0.

Test Plan:
- Reset, then RAM preloaded mem[i]=i+8'h10; start with last_addr=3 and out_ready=1 → words 10,11,12,13 on out_data; out_last only on 13; rd_addr sequence 0,1,2,3; done pulses once, 1 cycle after the 13 handshake.
- last_addr=0, out_ready=1 → single word 10 with out_last=1; out_valid first high 3 cycles after start; busy high for exactly 4 cycles.
- last_addr=63, out_ready toggling 1/0 every cycle → 64 words 10..4F in order; out_data stable while out_valid=1 and out_ready=0; no rd_en while stalled.
- start asserted again during PRESENT of word 1 (last_addr=5) → ignored; the readout continues to completion with 6 words and a single done pulse.
- reset asserted in WAIT of word 2 → next cycle all outputs 0 and state IDLE, no done pulse; a fresh start then reads from address 0.
- With READ_DESCEND_EN defined: descend=1, last_addr=3 → rd_addr 3,2,1,0; words 13,12,11,10; out_last on 10.
